// File: rtl/noc_funnel_tx.sv
// Purpose : serialise one NOCDataH packet (128b data + 16b length) into a header word plus ceil(min(len,16)/bytes-per-word) payload words.
// Latency : header offered 1 cycle after the input transfer, payload word 0 at the earliest 2 cycles after it.
// Backpr. : out_enq_rdy low freezes state, idx and out_enq_dat; input accepted only in IDLE (no comb path out->in rdy).
module noc_funnel_tx #(
    parameter int dataWidth   = 32,
    parameter int funnelWidth = 99
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 in_enq_vld,
    input  logic [143:0]         in_enq_dat,
    output logic                 in_enq_rdy,
    output logic                 out_enq_vld,
    output logic [dataWidth-1:0] out_enq_dat,
    input  logic                 out_enq_rdy,
    output logic                 busy
);

    localparam int BPW    = dataWidth / 8;
    localparam int BPW_SH = $clog2(BPW);
    localparam int DW_SH  = $clog2(dataWidth);

    // funnelWidth only shapes the downstream interface type; it is checked
    // here so an illegal instantiation is caught at elaboration.
    if (!((dataWidth == 32) || (dataWidth == 64) || (dataWidth == 128)) || (funnelWidth < 1)) begin : g_param_check
        $error("noc_funnel_tx: dataWidth must be 32, 64 or 128 and funnelWidth positive");
    end

    typedef struct packed {
        logic [127:0] data;
        logic [15:0]  length;
    } noc_data_h_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        BODY = 2'd2
    } state_e;

    noc_data_h_t in_pkt;
    assign in_pkt = in_enq_dat;

    state_e       state_q,  state_d;
    logic [127:0] data_q,   data_d;
    logic [15:0]  len_q,    len_d;
    logic [4:0]   nwords_q, nwords_d;
    logic [4:0]   idx_q,    idx_d;

    logic [4:0]   nbytes;
    logic [4:0]   nwords_calc;
    logic         in_xfer;
    logic         out_xfer;

    // Byte count clamps at 16; 16 + (BPW-1) <= 31 so 5 bits never overflow.
    always_comb begin
        nbytes      = (in_pkt.length > 16'd16) ? 5'd16 : in_pkt.length[4:0];
        nwords_calc = (nbytes + 5'(BPW - 1)) >> BPW_SH;
    end

    // State register
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q  <= IDLE;
            data_q   <= '0;
            len_q    <= '0;
            nwords_q <= '0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            len_q    <= len_d;
            nwords_q <= nwords_d;
            idx_q    <= idx_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        len_d    = len_q;
        nwords_d = nwords_q;
        idx_d    = idx_q;
        in_xfer  = in_enq_vld && (state_q == IDLE);
        out_xfer = ((state_q == HDR) || (state_q == BODY)) && out_enq_rdy;

        case (state_q)
            IDLE: begin
                if (in_xfer) begin
                    data_d   = in_pkt.data;
                    len_d    = in_pkt.length;
                    nwords_d = nwords_calc;
                    idx_d    = '0;
                    state_d  = HDR;
                end
            end
            HDR: begin
                if (out_xfer) begin
                    state_d = (nwords_q == 5'd0) ? IDLE : BODY;
                end
            end
            BODY: begin
                if (out_xfer) begin
                    idx_d = idx_q + 5'd1;
                    if (idx_q == (nwords_q - 5'd1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    logic [31:0]  shamt;
    logic [127:0] shifted;

    always_comb begin
        shamt       = 32'(idx_q) << DW_SH;
        shifted     = data_q >> shamt;
        in_enq_rdy  = (state_q == IDLE);
        busy        = (state_q != IDLE);
        out_enq_vld = ((state_q == HDR) || (state_q == BODY)) && out_enq_rdy;
        out_enq_dat = '0;
        case (state_q)
            HDR:     out_enq_dat = dataWidth'(len_q);
            BODY:    out_enq_dat = shifted[dataWidth-1:0];
            default: out_enq_dat = '0;
        endcase
    end

endmodule

// File: tb/tb_noc_funnel_tx.sv
module tb_noc_funnel_tx;

    logic         clk;
    logic         nrst;

    // dataWidth = 32 instance
    logic         in_ena;
    logic [143:0] in_v;
    logic         in_rdy;
    logic         out_ena;
    logic [31:0]  out_v;
    logic         out_rdy;
    logic         busy;

    // dataWidth = 128 instance
    logic         in_ena_w;
    logic [143:0] in_v_w;
    logic         in_rdy_w;
    logic         out_ena_w;
    logic [127:0] out_v_w;
    logic         out_rdy_w;
    logic         busy_w;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int words32 = 0;

    logic [127:0] q32[$];
    logic [127:0] q128[$];

    noc_funnel_tx #(.dataWidth(32), .funnelWidth(99)) u_dut32 (
        .CLK(clk), .nRST(nrst),
        .in_enq_vld(in_ena), .in_enq_dat(in_v), .in_enq_rdy(in_rdy),
        .out_enq_vld(out_ena), .out_enq_dat(out_v), .out_enq_rdy(out_rdy),
        .busy(busy)
    );

    noc_funnel_tx #(.dataWidth(128), .funnelWidth(99)) u_dut128 (
        .CLK(clk), .nRST(nrst),
        .in_enq_vld(in_ena_w), .in_enq_dat(in_v_w), .in_enq_rdy(in_rdy_w),
        .out_enq_vld(out_ena_w), .out_enq_dat(out_v_w), .out_enq_rdy(out_rdy_w),
        .busy(busy_w)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitors: pop one expected word per output transfer.
    always @(negedge clk) begin
        if (nrst === 1'b1) begin
            if (out_rdy === 1'b0) chk("dw32_ena_while_stalled", 128'(out_ena), 128'd0);
            if (out_ena === 1'b1) begin
                words32++;
                if (q32.size() == 0) chk("dw32_unexpected_word", 128'(out_v), 128'hx);
                else chk("dw32_word", 128'(out_v), q32.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (nrst === 1'b1 && out_ena_w === 1'b1) begin
            if (q128.size() == 0) chk("dw128_unexpected_word", out_v_w, 128'hx);
            else chk("dw128_word", out_v_w, q128.pop_front());
        end
    end

    // Called just after a rising edge; returns just after the input transfer edge.
    task automatic send32(input logic [15:0] len, input logic [127:0] dat);
        int n = 0;
        while (in_rdy !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (in_rdy !== 1'b1) chk("dw32_in_rdy_timeout", 128'(in_rdy), 128'd1);
        in_v   = {dat, len};
        in_ena = 1'b1;
        @(posedge clk); #1;
        in_ena = 1'b0;
    endtask

    task automatic wait_idle32();
        int n = 0;
        @(negedge clk);
        while (busy === 1'b1 && n < 50) begin
            @(negedge clk); n++;
        end
        chk("dw32_idle_timeout", 128'(busy), 128'd0);
        @(posedge clk); #1;
    endtask

    localparam logic [127:0] D_INC = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    localparam logic [127:0] D_B   = 128'hFFEEDDCC_BBAA9988_77665544_33221100;
    localparam logic [127:0] D_C   = 128'hDEADBEEF_CAFEBABE_12345678_9ABCDEF0;
    localparam logic [127:0] D_S   = 128'h00000000_11111111_AAAABBBB_CCCCDDDD;

    initial begin
        int w0;
        int t_prev;
        int n;
        nrst      = 1'b0;
        in_ena    = 1'b0;
        in_v      = '0;
        out_rdy   = 1'b1;
        in_ena_w  = 1'b0;
        in_v_w    = '0;
        out_rdy_w = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        nrst = 1'b1;
        @(negedge clk);
        chk("rst_busy",    128'(busy),    128'd0);
        chk("rst_in_rdy",  128'(in_rdy),  128'd1);
        chk("rst_out_ena", 128'(out_ena), 128'd0);
        chk("rst_out_v",   128'(out_v),   128'd0);
        chk("rst_w_out_v", out_v_w,       128'd0);
        @(posedge clk); #1;

        // Basic length 16: five words on consecutive cycles, RDY back after.
        q32.push_back(128'h10);
        q32.push_back(128'h03020100);
        q32.push_back(128'h07060504);
        q32.push_back(128'h0B0A0908);
        q32.push_back(128'h0F0E0D0C);
        w0 = words32;
        send32(16'd16, D_INC);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k <= 5) chk("basic_ena_each_cycle", 128'(out_ena), 128'd1);
            if (k == 5) chk("basic_in_rdy_busy", 128'(in_rdy), 128'd0);
            if (k == 6) chk("basic_in_rdy_back", 128'(in_rdy), 128'd1);
        end
        chk("basic_word_count", 128'(words32 - w0), 128'd5);
        @(posedge clk); #1;

        // Partial length: high bytes of last word are not masked.
        q32.push_back(128'h5);
        q32.push_back(128'h33221100);
        q32.push_back(128'h77665544);
        send32(16'd5, D_B);
        wait_idle32();

        // Zero length: header only, idle immediately after.
        q32.push_back(128'h0);
        send32(16'd0, D_B);
        @(negedge clk);
        chk("zero_hdr_offered", 128'(out_ena), 128'd1);
        @(negedge clk);
        chk("zero_idle_busy",   128'(busy),   128'd0);
        chk("zero_idle_in_rdy", 128'(in_rdy), 128'd1);
        @(posedge clk); #1;

        // Clamp: unclamped header, exactly 4 payload words.
        q32.push_back(128'h00000100);
        q32.push_back(128'h9ABCDEF0);
        q32.push_back(128'h12345678);
        q32.push_back(128'hCAFEBABE);
        q32.push_back(128'hDEADBEEF);
        send32(16'h0100, D_C);
        wait_idle32();

        // Backpressure after the header transfer.
        q32.push_back(128'h8);
        q32.push_back(128'hCCCCDDDD);
        q32.push_back(128'hAAAABBBB);
        send32(16'd8, D_S);
        @(posedge clk); #1;
        out_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_out_v_hold", 128'(out_v),   128'hCCCCDDDD);
            chk("stall_no_ena",     128'(out_ena), 128'd0);
            chk("stall_busy",       128'(busy),    128'd1);
        end
        out_rdy = 1'b1;
        wait_idle32();

        // Reset mid-packet after header and word 0.
        q32.push_back(128'h10);
        q32.push_back(128'h03020100);
        send32(16'd16, D_INC);
        @(posedge clk); #1;
        @(posedge clk); #1;
        out_rdy = 1'b0;
        nrst    = 1'b0;
        @(posedge clk); #1;
        nrst    = 1'b1;
        out_rdy = 1'b1;
        @(negedge clk);
        chk("midrst_busy",    128'(busy),    128'd0);
        chk("midrst_out_ena", 128'(out_ena), 128'd0);
        chk("midrst_in_rdy",  128'(in_rdy),  128'd1);
        chk("midrst_out_v",   128'(out_v),   128'd0);
        chk("midrst_queue_drained", 128'(q32.size()), 128'd0);
        @(posedge clk); #1;
        q32.push_back(128'h5);
        q32.push_back(128'h33221100);
        q32.push_back(128'h77665544);
        send32(16'd5, D_B);
        wait_idle32();

        // dataWidth=128: header + full data, back-to-back every 3 cycles.
        t_prev = 0;
        for (int p = 0; p < 3; p++) begin
            logic [127:0] d;
            d = (p == 0) ? D_INC : ((p == 1) ? D_B : D_C);
            q128.push_back(128'h10);
            q128.push_back(d);
            n = 0;
            while (in_rdy_w !== 1'b1 && n < 50) begin
                @(posedge clk); #1; n++;
            end
            if (in_rdy_w !== 1'b1) chk("dw128_in_rdy_timeout", 128'(in_rdy_w), 128'd1);
            in_v_w   = {d, 16'd16};
            in_ena_w = 1'b1;
            @(posedge clk); #1;
            in_ena_w = 1'b0;
            if (p > 0) chk("dw128_pkt_spacing", 128'(cyc - t_prev), 128'd3);
            t_prev = cyc;
        end

        // Drain both scoreboards.
        n = 0;
        while ((q32.size() != 0 || q128.size() != 0) && n < 100) begin
            @(posedge clk); #1; n++;
        end
        @(negedge clk);
        chk("final_q32_empty",  128'(q32.size()),  128'd0);
        chk("final_q128_empty", 128'(q128.size()), 128'd0);
        chk("final_w_idle",     128'(busy_w),      128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
